sys_bus_arbiter: RTL and testbench

Shares the single system memory port between the instruction cache and the data cache miss/write paths. It accepts one strobe-held request from each cache and picks one by 2-way round-robin when both are pending. It drives the memory port for a fixed number of wait states, then returns a one-cycle ready to the granted cache. It sits between the two cache controllers' Sys* buses and the external system memory.

---
 rtl/cache_defs.sv | 19 +
 rtl/rr_pick2.sv | 24 ++
 rtl/sys_bus_arbiter.sv | 117 +++++++++++
 tb/tb_sys_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_defs.sv
// Shared definitions for the cache-side system bus.
// Encodings for bus direction, grant owner and arbiter FSM state.
package cache_defs;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int DEF_WAIT_STATES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick between icache and dcache.
// On a tie the side that did not win last time is chosen.
module rr_pick2
  import cache_defs::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  // Combinational winner selection
  always_comb begin
    valid = req_i | req_d;
    grant = GRANT_I;
    if (req_i && req_d) begin
      grant = ~last_grant;
    end else if (req_d) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Shares the system memory port between icache and dcache.
// Fixed-latency access, one-cycle Ready back to the winner.
module sys_bus_arbiter
  import cache_defs::*;
#(
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          IStrobe,
  input  logic [AW-1:0] IAddress,
  output logic          IReady,
  output logic [DW-1:0] IRdata,
  input  logic          DStrobe,
  input  logic          DRw,
  input  logic [AW-1:0] DAddress,
  input  logic [DW-1:0] DWdata,
  output logic          DReady,
  output logic [DW-1:0] DRdata,
  output logic          MemStrobe,
  output logic          MemRW,
  output logic [AW-1:0] MemAddress,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  output logic          Grant
);

  localparam int CW = (WAIT_STATES < 1) ? 1
                    : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(WAIT_STATES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          pick_valid;
  logic          pick_grant;

  rr_pick2 u_pick (
    .req_i      (IStrobe),
    .req_d      (DStrobe),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // Arbiter FSM with all bus outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= GRANT_D;
      Grant      <= GRANT_I;
      MemStrobe  <= 1'b0;
      MemRW      <= RW_READ;
      MemAddress <= '0;
      MemWdata   <= '0;
      IReady     <= 1'b0;
      DReady     <= 1'b0;
      IRdata     <= '0;
      DRdata     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          IReady <= 1'b0;
          DReady <= 1'b0;
          if (pick_valid) begin
            state      <= ST_ACCESS;
            cnt        <= CNT_LOAD;
            MemStrobe  <= 1'b1;
            Grant      <= pick_grant;
            last_grant <= pick_grant;
            if (pick_grant == GRANT_D) begin
              MemRW      <= DRw;
              MemAddress <= DAddress;
              MemWdata   <= DWdata;
            end else begin
              MemRW      <= RW_READ;
              MemAddress <= IAddress;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state     <= ST_DONE;
            MemStrobe <= 1'b0;
            if (Grant == GRANT_D) begin
              DReady <= 1'b1;
              if (MemRW == RW_READ) begin
                DRdata <= MemRdata;
              end
            end else begin
              IReady <= 1'b1;
              IRdata <= MemRdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          IReady <= 1'b0;
          DReady <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          MemStrobe <= 1'b0;
          IReady    <= 1'b0;
          DReady    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Scoreboard bench for sys_bus_arbiter.
// Requesters push expectations; a negedge monitor checks them.
module tb_sys_bus_arbiter;

  localparam int WS = 2;

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        IStrobe, DStrobe, DRw;
  logic [31:0] IAddress, DAddress, DWdata;
  logic        IReady, DReady, MemStrobe, MemRW, Grant;
  logic [31:0] IRdata, DRdata, MemAddress, MemWdata;
  logic [31:0] MemRdata;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sc = 0;
  exp_t qi[$];
  exp_t qd[$];
  exp_t me;
  bit   hit;

  sys_bus_arbiter #(.WAIT_STATES(WS), .AW(32), .DW(32)) dut (
    .clock(clk), .reset(reset),
    .IStrobe(IStrobe), .IAddress(IAddress),
    .IReady(IReady), .IRdata(IRdata),
    .DStrobe(DStrobe), .DRw(DRw), .DAddress(DAddress),
    .DWdata(DWdata), .DReady(DReady), .DRdata(DRdata),
    .MemStrobe(MemStrobe), .MemRW(MemRW),
    .MemAddress(MemAddress), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .Grant(Grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // strobe-cycle counter so data is only valid in the last cycle
  always @(posedge clk) begin
    if (reset || !MemStrobe) sc <= 0;
    else sc <= sc + 1;
  end

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    return (a ^ 32'h5A5A_0000) + 32'h11;
  endfunction

  assign MemRdata = (MemStrobe && sc == WS - 1)
                    ? mem_model(MemAddress) : 32'hBAD0_BAD0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit in_win(input int r);
    return (cyc >= r - WS) && (cyc < r);
  endfunction

  // monitor: pops on Ready, checks Mem* inside strobe windows
  always @(negedge clk) begin
    if (!reset) begin
      if (IReady && DReady) begin
        checks++; errors++;
        $display("FAIL both_ready: got 1/1 want one-hot at %0d", cyc);
      end
      if (IReady) begin
        if (qi.size() == 0) begin
          checks++; errors++;
          $display("FAIL i_unexpected: got IReady=1 want 0 at %0d", cyc);
        end else begin
          me = qi.pop_front();
          chk("i_ready_cycle", cyc, me.rdy);
          chk("i_rdata", IRdata, me.rdata);
          chk("i_grant", {31'b0, Grant}, 32'd0);
        end
      end
      if (DReady) begin
        if (qd.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_unexpected: got DReady=1 want 0 at %0d", cyc);
        end else begin
          me = qd.pop_front();
          chk("d_ready_cycle", cyc, me.rdy);
          if (me.rw) chk("d_rdata", DRdata, me.rdata);
          chk("d_grant", {31'b0, Grant}, 32'd1);
        end
      end
      hit = 1'b0;
      if (qi.size() > 0 && in_win(qi[0].rdy)) begin
        hit = 1'b1; me = qi[0];
      end else if (qd.size() > 0 && in_win(qd[0].rdy)) begin
        hit = 1'b1; me = qd[0];
      end
      if (hit) begin
        chk("mem_strobe", {31'b0, MemStrobe}, 32'd1);
        chk("mem_addr", MemAddress, me.addr);
        chk("mem_rw", {31'b0, MemRW}, {31'b0, me.rw});
        if (!me.rw) chk("mem_wdata", MemWdata, me.wdata);
      end else if (MemStrobe) begin
        checks++; errors++;
        $display("FAIL mem_strobe_idle: got 1 want 0 at %0d", cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_i(input logic [31:0] a, input int rdy,
                      input bit mut);
    bit got;
    qi.push_back('{rw: 1'b1, addr: a, wdata: 32'h0,
                   rdata: mem_model(a), rdy: rdy});
    IStrobe = 1'b1;
    IAddress = a;
    if (mut) begin
      tick();
      IAddress = ~a;
    end
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = IReady;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL i_timeout: got no IReady want cycle %0d", rdy);
    end
    tick();
    IStrobe = 1'b0;
  endtask

  task automatic do_d(input bit rw, input logic [31:0] a,
                      input logic [31:0] w, input int rdy,
                      input bit mut);
    bit got;
    qd.push_back('{rw: rw, addr: a, wdata: w,
                   rdata: mem_model(a), rdy: rdy});
    DStrobe = 1'b1;
    DRw = rw;
    DAddress = a;
    DWdata = w;
    if (mut) begin
      tick();
      DAddress = ~a;
      DWdata = ~w;
      DRw = ~rw;
    end
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = DReady;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL d_timeout: got no DReady want cycle %0d", rdy);
    end
    tick();
    DStrobe = 1'b0;
  endtask

  task automatic pulse_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1;
    IStrobe = 1'b0; DStrobe = 1'b0; DRw = 1'b1;
    IAddress = '0; DAddress = '0; DWdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memstrobe", {31'b0, MemStrobe}, 32'd0);
    chk("rst_memrw", {31'b0, MemRW}, 32'd1);
    chk("rst_memaddr", MemAddress, 32'h0);
    chk("rst_memwdata", MemWdata, 32'h0);
    chk("rst_iready", {31'b0, IReady}, 32'd0);
    chk("rst_dready", {31'b0, DReady}, 32'd0);
    chk("rst_irdata", IRdata, 32'h0);
    chk("rst_drdata", DRdata, 32'h0);
    chk("rst_grant", {31'b0, Grant}, 32'd0);
    tick();
    reset = 1'b0;

    // single icache read and single dcache write
    t = cyc;
    do_i(32'h0000_1004, t + 3, 1'b0);
    t = cyc;
    do_d(1'b0, 32'h0000_2000, 32'h1234_5678, t + 3, 1'b0);

    // ties from reset alternate I, D, I, D
    pulse_reset();
    t = cyc;
    fork
      begin
        do_i(32'h0000_1100, t + 3, 1'b0);
        do_i(32'h0000_1104, t + 11, 1'b0);
      end
      begin
        do_d(1'b1, 32'h0000_2200, 32'h0, t + 7, 1'b0);
        do_d(1'b0, 32'h0000_2204, 32'h55AA_55AA, t + 15, 1'b0);
      end
    join

    // DStrobe held, IStrobe pulsed: one transaction max wait
    t = cyc;
    fork
      begin
        do_i(32'h0000_7000, t + 3, 1'b0);
        tick();
        do_i(32'h0000_7004, t + 11, 1'b0);
        tick();
        do_i(32'h0000_7008, t + 19, 1'b0);
      end
      begin
        do_d(1'b1, 32'h0000_6000, 32'h0, t + 7, 1'b0);
        do_d(1'b0, 32'h0000_6100, 32'h0BAD_F00D, t + 15, 1'b0);
        do_d(1'b1, 32'h0000_6200, 32'h0, t + 23, 1'b0);
      end
    join

    // inputs change during ACCESS; Mem* must stay latched
    t = cyc;
    do_d(1'b0, 32'h0000_4000, 32'hCAFE_F00D, t + 3, 1'b1);
    t = cyc;
    do_i(32'h0000_5008, t + 3, 1'b1);

    // reset during first ACCESS cycle abandons the access
    t = cyc;
    qi.push_back('{rw: 1'b1, addr: 32'h0000_3000, wdata: 32'h0,
                   rdata: mem_model(32'h0000_3000), rdy: t + 3});
    IStrobe = 1'b1;
    IAddress = 32'h0000_3000;
    tick();
    IStrobe = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    qi.delete();
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_memstrobe", {31'b0, MemStrobe}, 32'd0);
    chk("abort_iready", {31'b0, IReady}, 32'd0);
    chk("abort_dready", {31'b0, DReady}, 32'd0);
    tick();
    t = cyc;
    do_i(32'h0000_3004, t + 3, 1'b0);

    repeat (3) tick();
    chk("qi_drained", qi.size(), 32'd0);
    chk("qd_drained", qd.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
